// File: rtl/traffic_gen_pkg.sv
// traffic_gen_pkg
// Shared definitions for the multi-channel traffic generator:
//   - one-hot FSM state encoding (IDLE/RUN/DONE)
//   - run-mode encoding (INC/ROT/GAP; the unused code 3 behaves as INC)
//   - word_lsb(): bit position of channel c inside the packed data bus
package traffic_gen_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    RUN  = 3'b010,
    DONE = 3'b100
  } state_e;

  typedef enum logic [1:0] {
    MODE_INC = 2'd0,
    MODE_ROT = 2'd1,
    MODE_GAP = 2'd2
  } mode_e;

  // Lowest bit of channel c's word in a {ch[N-1], ..., ch[0]} packed bus.
  function automatic int word_lsb(input int c, input int data_w);
    return c * data_w;
  endfunction

endpackage

// File: rtl/traffic_gen_if.sv
// traffic_gen_if
// Control, status and FIFO-write bundle of the traffic generator.
//   master : the generator (drives wr_enb/data_out/busy/done/dbg_state)
//   slave  : the controller and FIFO side (drives start/stop/mode/
//            burst_len/seed/fifo_full)
// Handshake: there is no ready path; a word is written in every cycle where
// wr_enb[c]=1 and data_out[c] is valid in that same cycle. fifo_full[c] is
// an almost-full hint sampled at the clock edge; it only blocks the word
// that would appear after that edge, so the FIFO must keep one spare entry.
interface traffic_gen_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 10,
  parameter int DEST_W = 2,
  parameter int CNT_W  = 8
);
  localparam int PW = DATA_W - DEST_W;

  logic                     start;
  logic                     stop;
  logic [1:0]               mode;
  logic [CNT_W-1:0]         burst_len;
  logic [PW-1:0]            seed;
  logic [NUM_CH-1:0]        fifo_full;
  logic [NUM_CH-1:0]        wr_enb;
  logic [NUM_CH*DATA_W-1:0] data_out;
  logic                     busy;
  logic                     done;
  logic [2:0]               dbg_state;  // current FSM state, one-hot

  modport master (
    input  start, stop, mode, burst_len, seed, fifo_full,
    output wr_enb, data_out, busy, done, dbg_state
  );

  modport slave (
    output start, stop, mode, burst_len, seed, fifo_full,
    input  wr_enb, data_out, busy, done, dbg_state
  );
endinterface

// File: rtl/traffic_gen_lane.sv
// traffic_gen_lane
// One channel of the traffic generator: remaining-word count, word index k,
// and the registered write enable / data word for that channel.
// Ports:
//   clk, rst      clock, async active-high reset
//   load_i        start accepted: rem <= burst_len_i, k <= 0
//   abort_i       stop in RUN: discard remaining words, no write this edge
//   run_en_i      FSM in RUN and not aborting
//   phase_ok_i    GAP-mode write window open (always 1 outside GAP)
//   full_i        almost-full from this channel's FIFO
//   burst_len_i   words to write in this run
//   seed_i        first payload value
//   mode_i        run mode (ROT rotates the destination field)
//   wr_enb_o      registered write enable
//   data_o        registered word {dest, payload}
//   lane_idle_o   no words left to write (rem = 0)
module traffic_gen_lane
  import traffic_gen_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int DEST_W = 2,
  parameter int CNT_W  = 8,
  parameter int LANE   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_i,
  input  logic                     abort_i,
  input  logic                     run_en_i,
  input  logic                     phase_ok_i,
  input  logic                     full_i,
  input  logic [CNT_W-1:0]         burst_len_i,
  input  logic [DATA_W-DEST_W-1:0] seed_i,
  input  logic [1:0]               mode_i,
  output logic                     wr_enb_o,
  output logic [DATA_W-1:0]        data_o,
  output logic                     lane_idle_o
);
  localparam int PW = DATA_W - DEST_W;

  logic [CNT_W-1:0]  rem_q;
  logic [CNT_W-1:0]  k_q;
  logic              wr_q;
  logic [DATA_W-1:0] data_q;

  logic              fire;
  logic [PW-1:0]     payload;
  logic [DEST_W-1:0] dest;

  always_comb begin
    fire    = run_en_i && (rem_q != '0) && !full_i && phase_ok_i;
    // Payload and destination both wrap naturally through their widths.
    payload = seed_i + PW'(k_q);
    dest    = DEST_W'(LANE);
    if (mode_i == MODE_ROT) begin
      dest = DEST_W'(LANE) + DEST_W'(k_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      k_q    <= '0;
      wr_q   <= 1'b0;
      data_q <= '0;
    end else if (load_i) begin
      rem_q <= burst_len_i;
      k_q   <= '0;
      wr_q  <= 1'b0;
    end else if (abort_i) begin
      rem_q <= '0;
      wr_q  <= 1'b0;
    end else if (fire) begin
      wr_q   <= 1'b1;
      data_q <= {dest, payload};
      k_q    <= k_q + 1'b1;
      rem_q  <= rem_q - 1'b1;
    end else begin
      // Stalled or finished: data_q deliberately holds the last word.
      wr_q <= 1'b0;
    end
  end

  assign wr_enb_o    = wr_q;
  assign data_o      = data_q;
  assign lane_idle_o = (rem_q == '0);

endmodule

// File: rtl/traffic_gen.sv
// traffic_gen
// Run-time configurable stimulus engine feeding NUM_CH input-FIFO write
// ports with destination-tagged words, honouring per-channel almost-full.
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-high reset
//   bus  traffic_gen_if.master: start/stop/mode/burst_len/seed/fifo_full in,
//        wr_enb/data_out/busy/done/dbg_state out
// The top holds the IDLE/RUN/DONE FSM, the GAP phase bit and the latched
// run configuration; per-channel counters live in traffic_gen_lane.
module traffic_gen
  import traffic_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 10,
  parameter int DEST_W = 2,
  parameter int CNT_W  = 8
) (
  input  logic           clk,
  input  logic           rst,
  traffic_gen_if.master  bus
);
  localparam int PW = DATA_W - DEST_W;

  state_e                   state_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     phase_q;
  logic [1:0]               mode_q;
  logic [PW-1:0]            seed_q;

  logic                     load;
  logic                     abort;
  logic                     run_en;
  logic                     phase_ok;
  logic                     all_idle;
  logic [NUM_CH-1:0]        idle_w;
  logic [NUM_CH-1:0]        wr_enb_w;
  logic [NUM_CH*DATA_W-1:0] data_w;

  always_comb begin
    load     = (state_q == IDLE) && bus.start;
    abort    = (state_q == RUN) && bus.stop;
    run_en   = (state_q == RUN) && !bus.stop;
    // Outside GAP every cycle is a write window; in GAP only phase 0.
    phase_ok = (mode_q != MODE_GAP) || !phase_q;
    all_idle = &idle_w;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      phase_q <= 1'b0;
      mode_q  <= MODE_INC;
      seed_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            mode_q  <= bus.mode;
            seed_q  <= bus.seed;
            phase_q <= 1'b0;
            if (bus.burst_len != '0) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          // Phase advances every RUN cycle, stalled or not.
          phase_q <= ~phase_q;
          if (bus.stop || all_idle) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    traffic_gen_lane #(
      .DATA_W (DATA_W),
      .DEST_W (DEST_W),
      .CNT_W  (CNT_W),
      .LANE   (c)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .load_i      (load),
      .abort_i     (abort),
      .run_en_i    (run_en),
      .phase_ok_i  (phase_ok),
      .full_i      (bus.fifo_full[c]),
      .burst_len_i (bus.burst_len),
      .seed_i      (seed_q),
      .mode_i      (mode_q),
      .wr_enb_o    (wr_enb_w[c]),
      .data_o      (data_w[word_lsb(c, DATA_W) +: DATA_W]),
      .lane_idle_o (idle_w[c])
    );
  end

  assign bus.wr_enb    = wr_enb_w;
  assign bus.data_out  = data_w;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_traffic_gen.sv
// tb_traffic_gen
// Directed test-plan runs plus randomized runs of traffic_gen, checked
// against a behavioural model that tracks words-left and word-index per
// channel and predicts each cycle's writes, status and data words.
module tb_traffic_gen;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 10;
  localparam int DEST_W = 2;
  localparam int CNT_W  = 8;
  localparam int PW     = DATA_W - DEST_W;
  localparam int W      = DATA_W;
  localparam int BUDGET = 1000;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  traffic_gen_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEST_W(DEST_W),
                   .CNT_W(CNT_W)) bus ();

  traffic_gen #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEST_W(DEST_W),
                .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_word[NUM_CH];
  logic [W-1:0] obs0[$];
  logic [W-1:0] obs1[$];

  int m_st;
  int m_mode;
  int m_seed;
  int m_t;
  int m_rem[NUM_CH];
  int m_k[NUM_CH];

  logic [NUM_CH-1:0] exp_wr;
  logic              exp_busy;
  logic              exp_done;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  function automatic logic [W-1:0] word(input int c, input int k);
    int dest;
    int pay;
    dest = (m_mode == 1) ? (c + k) % NUM_CH : c;
    pay  = (m_seed + k) % (1 << PW);
    return W'(dest * (1 << PW) + pay);
  endfunction

  task automatic model_reset();
    m_st = M_IDLE;
    m_t  = 0;
    exp_q.delete();
    for (int c = 0; c < NUM_CH; c++) begin
      m_rem[c] = 0;
      m_k[c] = 0;
      last_word[c] = '0;
    end
    exp_wr = '0;
    exp_busy = 1'b0;
    exp_done = 1'b0;
  endtask

  // Predict what the outputs will be after the coming clock edge, given the
  // inputs currently driven.
  task automatic model_step();
    bit all_zero;
    logic [W-1:0] w;
    exp_wr   = '0;
    exp_done = 1'b0;
    case (m_st)
      M_IDLE: begin
        if (bus.start) begin
          m_mode = (int'(bus.mode) == 3) ? 0 : int'(bus.mode);
          m_seed = int'(bus.seed);
          m_t = 0;
          for (int c = 0; c < NUM_CH; c++) begin
            m_rem[c] = int'(bus.burst_len);
            m_k[c] = 0;
          end
          if (bus.burst_len != 0) m_st = M_RUN;
          else begin
            m_st = M_DONE;
            exp_done = 1'b1;
          end
        end
      end
      M_RUN: begin
        all_zero = 1;
        for (int c = 0; c < NUM_CH; c++) if (m_rem[c] != 0) all_zero = 0;
        if (bus.stop) begin
          m_st = M_DONE;
          exp_done = 1'b1;
          for (int c = 0; c < NUM_CH; c++) m_rem[c] = 0;
        end else if (all_zero) begin
          m_st = M_DONE;
          exp_done = 1'b1;
        end else begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (m_rem[c] > 0 && !bus.fifo_full[c] &&
                (m_mode != 2 || (m_t % 2) == 0)) begin
              exp_wr[c] = 1'b1;
              w = word(c, m_k[c]);
              exp_q.push_back(w);
              last_word[c] = w;
              m_k[c] = (m_k[c] + 1) % (1 << CNT_W);
              m_rem[c]--;
            end
          end
        end
        m_t++;
      end
      default: m_st = M_IDLE;
    endcase
    exp_busy = (m_st == M_RUN);
  endtask

  function automatic logic [2:0] exp_state();
    case (m_st)
      M_RUN:   return 3'b010;
      M_DONE:  return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

  task automatic check_outputs();
    logic [W-1:0] d;
    logic [W-1:0] e;
    check("wr_enb", 64'(bus.wr_enb), 64'(exp_wr));
    check("busy", 64'(bus.busy), 64'(exp_busy));
    check("done", 64'(bus.done), 64'(exp_done));
    check("state", 64'(bus.dbg_state), 64'(exp_state()));
    for (int c = 0; c < NUM_CH; c++) begin
      d = bus.data_out[c*W +: W];
      if (exp_wr[c]) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check($sformatf("data_ch%0d", c), 64'(d), 64'(e));
        if (bus.wr_enb[c] && c == 0) obs0.push_back(d);
        if (bus.wr_enb[c] && c == 1) obs1.push_back(d);
      end else begin
        check($sformatf("hold_ch%0d", c), 64'(d), 64'(last_word[c]));
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int mode, input int bl, input int seed,
                     input int full_pct, input int stall_ch,
                     input int stall_from, input int stall_len,
                     input int stop_at, input bit start_spam,
                     output int done_edge);
    bit finished;
    done_edge = -1;
    finished = 0;
    obs0.delete();
    obs1.delete();
    bus.mode = 2'(mode);
    bus.burst_len = CNT_W'(bl);
    bus.seed = PW'(seed);
    for (int i = 0; i < BUDGET; i++) begin
      bus.start = (i == 0) || (start_spam && $urandom_range(0, 3) == 0);
      bus.stop = (i == stop_at);
      for (int c = 0; c < NUM_CH; c++) begin
        bus.fifo_full[c] = ($urandom_range(0, 99) < full_pct);
        if (c == stall_ch && i >= stall_from && i < stall_from + stall_len)
          bus.fifo_full[c] = 1'b1;
      end
      step();
      if (bus.done && done_edge < 0) done_edge = i;
      if (m_st == M_IDLE) begin
        finished = 1;
        break;
      end
    end
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.fifo_full = '0;
    check("run_finished", 64'(finished), 64'(1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int de;
    int r_mode, r_bl, r_seed, r_full, r_stop;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.mode = '0;
    bus.burst_len = '0;
    bus.seed = '0;
    bus.fifo_full = '0;
    model_reset();

    #2 rst = 1'b1;
    @(negedge clk);
    check_outputs();
    check("reset_data", 64'(bus.data_out), 64'(0));
    rst = 1'b0;

    // INC, seed 0xAA, 8 words
    run(0, 8, 'hAA, 0, -1, 0, 0, -1, 0, de);
    check("inc_done_edge", 64'(de), 64'(9));
    check("inc_ch0_first", 64'(obs0[0]), 64'('h0AA));
    check("inc_ch0_last", 64'(obs0[7]), 64'('h0B1));

    // ROT, seed 0, 4 words
    run(1, 4, 0, 0, -1, 0, 0, -1, 0, de);
    check("rot_ch1_0", 64'(obs1[0]), 64'('h100));
    check("rot_ch1_1", 64'(obs1[1]), 64'('h201));
    check("rot_ch1_2", 64'(obs1[2]), 64'('h302));
    check("rot_ch1_3", 64'(obs1[3]), 64'('h003));
    check("rot_ch0_3", 64'(obs0[3]), 64'('h303));

    // INC, 6 words, ch2 held full for 3 cycles mid-run
    run(0, 6, 'h10, 0, 2, 2, 3, -1, 0, de);
    check("stall_done_edge", 64'(de), 64'(10));

    // GAP, 3 words: writes on edges 1,3,5 then done
    run(2, 3, 'h40, 0, -1, 0, 0, -1, 0, de);
    check("gap_done_edge", 64'(de), 64'(6));

    // payload wrap
    run(0, 4, 'hFE, 0, -1, 0, 0, -1, 0, de);
    check("wrap_ch1_1", 64'(obs1[1]), 64'('h1FF));
    check("wrap_ch1_2", 64'(obs1[2]), 64'('h100));
    check("wrap_ch1_3", 64'(obs1[3]), 64'('h101));

    // burst_len = 0
    run(0, 0, 'h55, 0, -1, 0, 0, -1, 0, de);
    check("zero_done_edge", 64'(de), 64'(0));
    check("zero_no_writes", 64'(obs0.size()), 64'(0));

    // stop after the second write
    run(0, 8, 'h20, 0, -1, 0, 0, 3, 0, de);
    check("stop_done_edge", 64'(de), 64'(3));
    check("stop_write_count", 64'(obs0.size()), 64'(2));

    // asynchronous reset mid-run
    bus.mode = 2'd0;
    bus.burst_len = CNT_W'(8);
    bus.seed = PW'('h70);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    check("rst_wr_enb", 64'(bus.wr_enb), 64'(0));
    check("rst_data", 64'(bus.data_out), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run(0, 4, 'h33, 0, -1, 0, 0, -1, 0, de);
    check("post_rst_first", 64'(obs0[0]), 64'('h033));
    check("post_rst_done_edge", 64'(de), 64'(5));

    // randomized runs
    for (int n = 0; n < 40; n++) begin
      r_mode = $urandom_range(0, 3);
      r_bl   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 24);
      r_seed = ($urandom_range(0, 3) == 0) ? $urandom_range(240, 255)
                                           : $urandom_range(0, 255);
      r_full = $urandom_range(0, 40);
      r_stop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, r_bl + 2) : -1;
      run(r_mode, r_bl, r_seed, r_full, -1, 0, 0, r_stop, 1'b1, de);
      repeat ($urandom_range(0, 2)) step();
    end

    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_gen.md
# traffic_gen

Synthesizable, parametrised multi-channel stimulus generator for the FIFO/router datapath. It replaces the hand-written per-channel write sequences of the behavioural bench with a run-time-configurable engine. The engine drives NUM_CH input-FIFO write ports with destination-tagged words, honours per-channel almost-full backpressure, and signals completion. It sits in front of the input FIFOs, in both the bench and on-board self-test.

## Interface
Parameters:
- NUM_CH, 4, channel count (≥2, power of two)
- DATA_W, 10, word width
- DEST_W, 2, destination field width = log2(NUM_CH); occupies bits [DATA_W-1 -: DEST_W]
- CNT_W, 8, burst-length counter width

Payload width PW = DATA_W-DEST_W.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request to begin a run; sampled only in IDLE
- stop  in  1  synchronous abort; sampled only in RUN
- mode  in  2  0 INC, 1 ROT, 2 GAP, 3 treated as INC
- burst_len  in  CNT_W  words to write per channel
- seed  in  PW  first payload value
- fifo_full  in  NUM_CH  per-channel almost-full from input FIFOs
- wr_enb  out  NUM_CH  per-channel write enable (registered)
- data_out  out  NUM_CH*DATA_W  channel c at [c*DATA_W +: DATA_W] (registered)
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at end of run

## Operation
- FSM, one-hot: IDLE=1, RUN=2, DONE=4.
- IDLE: if start=1, latch mode, burst_len and seed, and load rem[c]=burst_len and k[c]=0 for every channel.
  - If burst_len≠0, go to RUN. If burst_len=0, go to DONE; no writes occur.
- RUN, each edge, per channel c:
  - Condition: rem[c]≠0, fifo_full[c]=0, and (mode≠GAP or phase=0).
  - If the condition holds: wr_enb[c]<=1, data_out[c]<=word(c,k[c]), k[c]<=k[c]+1, rem[c]<=rem[c]-1.
  - Otherwise: wr_enb[c]<=0 and data_out[c] holds its value.
- Word construction:
  - Payload = (seed + k) mod 2^PW, in all modes.
  - Destination in INC and GAP = c.
  - Destination in ROT = (c + k) mod NUM_CH.
- phase: cleared on entering RUN and toggles every RUN cycle, independent of stalls.
- RUN exit:
  - If all rem=0 at an edge, go to DONE and clear all wr_enb.
  - If stop=1 at an edge, go to DONE, clear all wr_enb, and discard the remaining counts. stop has priority over writes in that edge.
- DONE: lasts one cycle with done=1, then returns to IDLE. start is ignored in RUN and DONE.
- Channels are independent: a stalled channel does not stall the others.
  - Each channel's sequence has no gaps in k; stalls only delay words.

## Timing
- Reset values: state=IDLE, wr_enb=0, data_out=0, busy=0, done=0, all rem, k and phase = 0. Reset takes effect immediately, including mid-run; no partial words appear after it.
- Start latency:
  - start sampled at edge E0; busy=1 after E0.
  - First wr_enb after E1 (unstalled, phase 0).
- Write timing: a write occurs in each cycle where wr_enb[c]=1; data_out[c] is valid in the same cycle.
- Backpressure latency: fifo_full sampled at edge E blocks the word that would appear after E. The FIFO almost-full threshold must therefore leave at least 1 free entry.
- Unstalled INC run: burst_len consecutive write cycles per channel.
  - After the last write, the next edge clears wr_enb, sets done=1 and clears busy.
  - start-to-done = burst_len+2 edges.
- GAP: writes occur on alternate cycles; an unstalled run takes 2·burst_len−1 write-window cycles.
- Wrap-around: the payload wraps mod 2^PW, and k wraps mod 2^CNT_W without affecting rem.

## Structure
- traffic_gen_pkg:
  - State encodings IDLE/RUN/DONE.
  - Mode encodings MODE_INC/ROT/GAP.
  - Function for the word slice position.
- Sub-module traffic_gen_lane, instantiated NUM_CH times via generate:
  - Holds rem, k and the data/wr_enb registers for one channel.
  - Inputs: load, run_en, phase_ok, full, seed, mode, lane index.
  - Output: lane_idle (rem=0).
- Top level: FSM, phase bit, AND-reduction of lane_idle.

## Test plan
(All cases use defaults NUM_CH=4, DATA_W=10.)
- INC, seed=0xAA, burst_len=8, no full:
  - ch0 writes 0x0AA..0x0B1, ch3 writes 0x3AA..0x3B1, on 8 consecutive cycles.
  - done is high exactly 1 cycle, 10 edges after start.
- ROT, seed=0x00, burst_len=4: ch1 writes 0x100, 0x201, 0x302, 0x003; ch0 writes 0x000, 0x101, 0x202, 0x303.
- INC, burst_len=6, fifo_full[2] held high for 3 cycles mid-run:
  - ch2 has no wr_enb during the 3 cycles following the stall; its payload sequence stays contiguous.
  - The other channels are unaffected; done is delayed by 3 cycles.
- GAP, burst_len=3: wr_enb on each channel follows 1,0,1,0,1, then done.
- Wrap, INC, seed=0xFE, burst_len=4: ch1 payloads are 0xFE, 0xFF, 0x00, 0x01, with dest bits staying at 1.
- Boundary cases:
  - burst_len=0: done occurs 1 cycle after start, with no wr_enb.
  - stop after the 2nd write: wr_enb is 0 on the next edge, followed by a done pulse.
  - rst asserted mid-run: all outputs are 0 immediately; a subsequent start runs cleanly from k=0.
